// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        WAIT,
        MEM_WR,
        DONE
    } state_t;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines);
        return ADDR_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Core request/response and backing-RAM bus seen by the data cache.
interface dcache_if;
    import dcache_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              r_en;
    logic              w_en;
    logic              stall;
    logic [DATA_W-1:0] saida_cache;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output address, data, r_en, w_en, mem_rdata,
        input  stall, saida_cache, mem_addr, mem_wdata, mem_re, mem_we
    );

    modport slave (
        input  address, data, r_en, w_en, mem_rdata,
        output stall, saida_cache, mem_addr, mem_wdata, mem_re, mem_we
    );

endinterface

// File: rtl/dcache_array.sv
// Single-port line storage {valid, tag, data}; read data appears the cycle after the address.
module dcache_array #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the
// multicycle core's memory stage.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES   = 16,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    dcache_if.slave     bus,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int IDX_W  = idx_w(LINES);
    localparam int TAG_W  = tag_w(LINES);
    localparam int LINE_W = 1 + TAG_W + DATA_W;
    localparam int CNT_W  = $clog2(MEM_LAT + 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              is_store;
    logic              armed;
    logic [LINES-1:0]  valid;
    logic [CNT_W-1:0]  wait_cnt;

    logic [IDX_W-1:0]  arr_addr;
    logic              arr_we;
    logic [LINE_W-1:0] arr_wdata;
    logic [LINE_W-1:0] arr_rdata;
    logic              hit;

    wire [IDX_W-1:0] idx_q = addr_q[IDX_W-1:0];
    wire [TAG_W-1:0] tag_q = addr_q[ADDR_W-1:IDX_W];

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .WIDTH (LINE_W)
    ) u_array (
        .clk   (clk),
        .addr  (arr_addr),
        .we    (arr_we),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign hit = valid[idx_q] && arr_rdata[LINE_W-1]
              && (arr_rdata[DATA_W +: TAG_W] == tag_q);

    // In IDLE the array is addressed straight from the core so the line is ready in LOOKUP.
    always_comb begin
        arr_addr  = (state == IDLE) ? bus.address[IDX_W-1:0] : idx_q;
        arr_we    = 1'b0;
        arr_wdata = {1'b1, tag_q, data_q};
        if (state == LOOKUP && is_store && hit) begin
            arr_we = 1'b1;
        end else if (state == WAIT && wait_cnt == '0) begin
            arr_we    = 1'b1;
            arr_wdata = {1'b1, tag_q, bus.mem_rdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            addr_q          <= '0;
            data_q          <= '0;
            is_store        <= 1'b0;
            armed           <= 1'b1;
            valid           <= '0;
            wait_cnt        <= '0;
            hit_count       <= '0;
            miss_count      <= '0;
            bus.stall       <= 1'b0;
            bus.saida_cache <= '0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_re      <= 1'b0;
            bus.mem_we      <= 1'b0;
        end else begin
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;

            // Re-arm only once the core has released its enable, so a held request is not replayed.
            if (!bus.r_en && !bus.w_en) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (armed && (bus.r_en || bus.w_en)) begin
                        addr_q    <= bus.address;
                        data_q    <= bus.data;
                        is_store  <= bus.w_en;
                        armed     <= 1'b0;
                        bus.stall <= 1'b1;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (is_store) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= addr_q;
                        bus.mem_wdata <= data_q;
                        state         <= MEM_WR;
                    end else if (hit) begin
                        bus.saida_cache <= arr_rdata[DATA_W-1:0];
                        if (hit_count != 16'hFFFF) begin
                            hit_count <= hit_count + 16'd1;
                        end
                        bus.stall <= 1'b0;
                        state     <= DONE;
                    end else begin
                        if (miss_count != 16'hFFFF) begin
                            miss_count <= miss_count + 16'd1;
                        end
                        bus.mem_re   <= 1'b1;
                        bus.mem_addr <= addr_q;
                        state        <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    wait_cnt <= CNT_W'(MEM_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        bus.saida_cache <= bus.mem_rdata;
                        valid[idx_q]    <= 1'b1;
                        bus.stall       <= 1'b0;
                        state           <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                MEM_WR: begin
                    bus.stall <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache that answers the multicycle MIPS core's memory stage. It samples the core's `r_en`/`w_en`/`address`/`data`, holds `stall` high while it services the access, and returns load data on `saida_cache`. Misses and all stores go to a fixed-latency backing data RAM.

## Interface
- `LINES`, 16: number of one-word lines, a power of two; IDX_W = log2(LINES).
- `MEM_LAT`, 2: backing-RAM read latency in cycles, ≥1.
- `clk` in 1: system clock; the core's divided clock (`clk[25]`) is fed here.
- `rst` in 1: reset, asynchronous, active-high.
- `address` in 12: word address from the core; index = `address[IDX_W-1:0]`, tag = `address[11:IDX_W]`.
- `data` in 32: store data.
- `r_en` in 1: load request, held by the core for its whole memory stage.
- `w_en` in 1: store request, held likewise.
- `stall` out 1: registered busy flag.
- `saida_cache` out 32: registered load data.
- `mem_addr` out 12, `mem_wdata` out 32, `mem_re` out 1, `mem_we` out 1: backing-RAM request signals.
- `mem_rdata` in 32: backing-RAM read data.
- `hit_count` out 16, `miss_count` out 16: saturating load statistics.

## Operation
- States: IDLE, LOOKUP, MEM_RD, WAIT, MEM_WR, DONE.
- Reset values:
  - `stall`=0, `saida_cache`=0, `mem_*` outputs=0, counters=0.
  - All valid bits=0, `armed`=1, state=IDLE.
- Accept rule:
  - In IDLE, a request is accepted when `armed` and (`r_en` | `w_en`).
  - On accept: latch address, data and op; clear `armed`; issue the array read; go to LOOKUP; set `stall`=1.
- `armed` is set on any edge where `r_en`=`w_en`=0. This prevents re-accepting the enable the core still holds after DONE.
- If `r_en` and `w_en` are both high, the access is treated as a store.
- LOOKUP, hit = valid & tag match:
  - Load hit: `saida_cache` ← line data; `hit_count`++; go to DONE.
  - Load miss: `miss_count`++; go to MEM_RD.
  - Store, hit or miss: if hit, update the line data; go to MEM_WR. A store miss does not allocate.
- MEM_RD: `mem_re`=1 and `mem_addr`=latched address for exactly one cycle; go to WAIT.
- WAIT: counts MEM_LAT cycles. On the last edge it captures `mem_rdata` into `saida_cache`, writes the line (valid=1, tag, data), and goes to DONE.
- MEM_WR: `mem_we`=1, `mem_addr`, `mem_wdata` driven for one cycle; go to DONE.
- DONE: `stall`=0 for one cycle, then IDLE.
- `saida_cache` holds its value until the next load completes. The core reads it in write-back, after `stall` falls. Stores never change it.
- Counters saturate at 16'hFFFF.

## Timing
- Request sampled at edge 0. `stall` rises after edge 0 for every access, hits included. The core needs to see `stall`=1 and then 0.
- Load hit: `stall` high 1 cycle; `saida_cache` valid after edge 1.
- Load miss: `stall` high MEM_LAT+2 cycles (4 at default); data valid when `stall` falls.
- Store: `stall` high 2 cycles; `mem_we` pulses in the cycle after edge 1.
- `stall` and `saida_cache` change only on `clk` edges, so there are no combinational paths from request inputs to them.
- Reset mid-access:
  - Immediately returns to IDLE, clears valid bits, and drops `stall` and `mem_*`.
  - Any read data returned after reset is ignored.
- Back-to-back accesses: the earliest re-accept is 2 edges after DONE, because enables must drop once first.

## Structure
- Package `dcache_pkg`:
  - State enum.
  - ADDR_W=12, DATA_W=32.
  - Functions for IDX_W and TAG_W.
- Sub-module `dcache_array`: synchronous single-port RAM of LINES × (1+TAG_W+32) bits. Read data is available the cycle after the address. Valid bits live as a separate flop vector in the controller so reset can clear them asynchronously.

## Test plan
- Load miss then hit:
  - Stimulus: RAM[0x025]=0xDEADBEEF; load 0x025 twice.
  - First access: `stall` high 4 cycles, `mem_re` one pulse, `saida_cache`=0xDEADBEEF, `miss_count`=1.
  - Second access: `stall` high 1 cycle, no `mem_re`, `hit_count`=1.
- Store hit write-through:
  - Stimulus: after the above, store 0x12345678 to 0x025, then load 0x025.
  - Required: one `mem_we` with addr 0x025 and data 0x12345678; the load hits and returns 0x12345678.
- Conflict eviction:
  - Stimulus: load 0x025, then 0x035 (same index, LINES=16), then 0x025.
  - Required: three misses; the final data comes from RAM[0x025].
- Held enable:
  - Stimulus: keep `r_en` high for 3 cycles after DONE.
  - Required: no second access, `stall` stays 0, counters unchanged.
- Reset mid-miss:
  - Stimulus: assert `rst` during WAIT.
  - Required: `stall`=0 at once; the next load of the same address misses again.
  - Required: `saida_cache`=0 until that load completes.
